y_line_writer: RTL and testbench

Y_LINE_WRITER -- requirements
Module: y_line_writer

---
 rtl/y_line_writer_pkg.sv | 27 ++
 rtl/y_line_merge.sv | 19 +
 rtl/y_line_writer.sv | 175 +++++++++++++++++
 tb/tb_y_line_writer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y_line_writer_pkg.sv
// Shared widths, marker values and state encodings for the Y-memory line writer.
package y_line_writer_pkg;

  localparam int ADDR_W = 11;
  localparam int LINE_W = 256;
  localparam int ELEM_W = 16;

  localparam logic [15:0] SENTINEL = 16'hFFFF;
  localparam logic [10:0] RST_ADDR = 11'h7FF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAP   = 3'd3,
    ST_MERGE = 3'd4,
    ST_WR    = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_LINE = 2'd1,
    PEND_SENT = 2'd2
  } pend_t;

endpackage

// File: rtl/y_line_merge.sv
// Replaces one ELEM_W-wide slot of a line with a new element value.
module y_line_merge #(
  parameter int LINE_W = y_line_writer_pkg::LINE_W,
  parameter int ELEM_W = y_line_writer_pkg::ELEM_W
) (
  input  logic [LINE_W-1:0] lineIn,
  input  logic [3:0]        slot,
  input  logic [ELEM_W-1:0] data,
  output logic [LINE_W-1:0] lineOut
);
  import y_line_writer_pkg::*;

  // Slot k lives in bits [ELEM_W*k +: ELEM_W]
  always_comb begin
    lineOut = lineIn;
    lineOut[int'(slot) * ELEM_W +: ELEM_W] = data;
  end

endmodule

// File: rtl/y_line_writer.sv
// Coalesces a stream of element updates into read-modify-write line accesses
// on the Y memory, flushing the open line on a line change, timeout or sentinel.
module y_line_writer #(
  parameter int ADDR_W    = y_line_writer_pkg::ADDR_W,
  parameter int LINE_W    = y_line_writer_pkg::LINE_W,
  parameter int ELEM_W    = y_line_writer_pkg::ELEM_W,
  parameter int FLUSH_CYC = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_row,
  input  logic [ELEM_W-1:0] in_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rdEn,
  input  logic [LINE_W-1:0] mem_rdData,
  output logic              mem_wrEn,
  output logic [LINE_W-1:0] mem_wrData,
  output logic              done,
  output logic              drop
);
  import y_line_writer_pkg::*;

  localparam int CNT_W = $clog2(FLUSH_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYC - 1);

  state_t              state_r;
  pend_t               pendKind_r;
  logic [ADDR_W-1:0]   pendAddr_r;
  logic [3:0]          pendSlot_r;
  logic [ELEM_W-1:0]   pendData_r;
  logic [ADDR_W-1:0]   bufAddr_r;
  logic [LINE_W-1:0]   lineBuf_r;
  logic [CNT_W-1:0]    idleCnt_r;

  logic                accept_s;
  logic                isSent_s;
  logic                isDrop_s;
  logic [ADDR_W-1:0]   inAddr_s;
  logic [LINE_W-1:0]   mergeBase_s;
  logic [3:0]          mergeSlot_s;
  logic [ELEM_W-1:0]   mergeData_s;
  logic [LINE_W-1:0]   merged_s;

  assign accept_s = in_valid & in_ready;
  assign isSent_s = (in_row == SENTINEL);
  assign isDrop_s = in_row[15] & ~isSent_s;
  assign inAddr_s = ADDR_W'(in_row[14:4]);

  // CAP folds the pending entry into the fetched line; MERGE folds live entries into the buffer
  always_comb begin
    if (state_r == ST_CAP) begin
      mergeBase_s = mem_rdData;
      mergeSlot_s = pendSlot_r;
      mergeData_s = pendData_r;
    end else begin
      mergeBase_s = lineBuf_r;
      mergeSlot_s = in_row[3:0];
      mergeData_s = in_data;
    end
  end

  y_line_merge #(
    .LINE_W(LINE_W),
    .ELEM_W(ELEM_W)
  ) u_merge (
    .lineIn (mergeBase_s),
    .slot   (mergeSlot_s),
    .data   (mergeData_s),
    .lineOut(merged_s)
  );

  // Control FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      pendKind_r <= PEND_NONE;
      pendAddr_r <= {ADDR_W{1'b0}};
      pendSlot_r <= 4'd0;
      pendData_r <= {ELEM_W{1'b0}};
      bufAddr_r  <= {ADDR_W{1'b0}};
      lineBuf_r  <= {LINE_W{1'b0}};
      idleCnt_r  <= {CNT_W{1'b0}};
      in_ready   <= 1'b0;
      mem_addr   <= ADDR_W'(RST_ADDR);
      mem_rdEn   <= 1'b0;
      mem_wrEn   <= 1'b0;
      mem_wrData <= {LINE_W{1'b0}};
      done       <= 1'b0;
      drop       <= 1'b0;
    end else begin
      in_ready <= 1'b0;
      mem_addr <= ADDR_W'(RST_ADDR);
      mem_rdEn <= 1'b0;
      mem_wrEn <= 1'b0;
      done     <= 1'b0;
      drop     <= accept_s & isDrop_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s && isSent_s) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else if (accept_s && !isDrop_s) begin
            pendAddr_r <= inAddr_s;
            pendSlot_r <= in_row[3:0];
            pendData_r <= in_data;
            state_r    <= ST_RD;
            mem_rdEn   <= 1'b1;
            mem_addr   <= inAddr_s;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_RD:   state_r <= ST_WAIT;
        ST_WAIT: state_r <= ST_CAP;
        ST_CAP: begin
          lineBuf_r  <= merged_s;
          bufAddr_r  <= pendAddr_r;
          pendKind_r <= PEND_NONE;
          idleCnt_r  <= {CNT_W{1'b0}};
          in_ready   <= 1'b1;
          state_r    <= ST_MERGE;
        end
        ST_MERGE: begin
          if (accept_s && !isDrop_s && !isSent_s && (inAddr_s == bufAddr_r)) begin
            lineBuf_r <= merged_s;
            idleCnt_r <= {CNT_W{1'b0}};
            in_ready  <= 1'b1;
          end else if ((accept_s && !isDrop_s) || (idleCnt_r == CNT_LAST)) begin
            // A real accept always becomes the pending entry; only a pure timeout leaves none
            if (accept_s && !isDrop_s) begin
              pendKind_r <= isSent_s ? PEND_SENT : PEND_LINE;
            end else begin
              pendKind_r <= PEND_NONE;
            end
            pendAddr_r <= inAddr_s;
            pendSlot_r <= in_row[3:0];
            pendData_r <= in_data;
            state_r    <= ST_WR;
            mem_wrEn   <= 1'b1;
            mem_addr   <= bufAddr_r;
            mem_wrData <= lineBuf_r;
          end else begin
            idleCnt_r <= idleCnt_r + CNT_W'(1);
            in_ready  <= 1'b1;
          end
        end
        ST_WR: begin
          case (pendKind_r)
            PEND_LINE: begin
              state_r  <= ST_RD;
              mem_rdEn <= 1'b1;
              mem_addr <= pendAddr_r;
            end
            PEND_SENT: begin
              state_r <= ST_DONE;
              done    <= 1'b1;
            end
            default: begin
              state_r  <= ST_IDLE;
              in_ready <= 1'b1;
            end
          endcase
        end
        ST_DONE: begin
          state_r  <= ST_IDLE;
          in_ready <= 1'b1;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y_line_writer.sv
// Self-checking bench: directed vector table, multi-cycle sequences and a
// randomized stream checked against a line-level memory reference model.
module tb_y_line_writer;
  localparam int FLUSH_CYC = 16;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_row;
  logic [15:0]  in_data;
  logic [10:0]  mem_addr;
  logic         mem_rdEn;
  logic [255:0] mem_rdData;
  logic         mem_wrEn;
  logic [255:0] mem_wrData;
  logic         done;
  logic         drop;

  y_line_writer #(.FLUSH_CYC(FLUSH_CYC)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_data(in_data), .mem_addr(mem_addr), .mem_rdEn(mem_rdEn),
    .mem_rdData(mem_rdData), .mem_wrEn(mem_wrEn), .mem_wrData(mem_wrData),
    .done(done), .drop(drop)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           cyc;
    bit           wr;
    logic [10:0]  addr;
    logic [255:0] data;
  } ev_t;

  typedef struct {
    logic [15:0]  row;
    logic [15:0]  data;
    int           expRd;
    int           expWr;
    int           expDrop;
    logic [10:0]  expAddr;
    logic [255:0] expLine;
  } vec_t;

  logic [255:0] memArr [0:2047];
  logic [255:0] refMem [0:2047];
  logic [255:0] rdPipe;
  logic         loadMem;
  logic         monOn;
  int           cycCnt = 0;
  int           doneCount = 0;
  int           dropCount = 0;
  int           lastDoneCyc = 0;
  int           overlapCnt = 0;
  int           badAddrCnt = 0;
  ev_t          evLog[$];
  int           checks = 0;
  int           failures = 0;

  // Y memory: two-cycle read latency, write on strobe
  always @(posedge clock) begin
    cycCnt <= cycCnt + 1;
    if (loadMem) begin
      for (int i = 0; i < 2048; i++) memArr[i] <= refMem[i];
    end else if (mem_wrEn) begin
      memArr[mem_addr] <= mem_wrData;
    end
    rdPipe     <= memArr[mem_addr];
    mem_rdData <= rdPipe;
  end

  // Bus monitor sampling on the falling edge
  always @(negedge clock) begin
    if (monOn) begin
      if (mem_rdEn && mem_wrEn) overlapCnt <= overlapCnt + 1;
      if (!mem_rdEn && !mem_wrEn && mem_addr != 11'h7FF) badAddrCnt <= badAddrCnt + 1;
      if (mem_rdEn || mem_wrEn) evLog.push_back('{cyc: cycCnt, wr: mem_wrEn, addr: mem_addr, data: mem_wrData});
      if (done) begin
        doneCount   <= doneCount + 1;
        lastDoneCyc <= cycCnt;
      end
      if (drop) dropCount <= dropCount + 1;
    end
  end

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic checkLine(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mkLine(input int slot, input logic [15:0] data);
    logic [255:0] l;
    l = 256'd0;
    l[slot*16 +: 16] = data;
    return l;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept
  task automatic sendEntry(input logic [15:0] row, input logic [15:0] data, output int accCyc);
    int waitCyc;
    waitCyc  = 0;
    in_valid = 1'b1;
    in_row   = row;
    in_data  = data;
    while (!in_ready && waitCyc < 200) begin
      @(negedge clock);
      waitCyc++;
    end
    checkInt("send_ready", int'(in_ready), 1);
    accCyc = cycCnt;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic loadRef();
    loadMem = 1'b1;
    @(negedge clock);
    loadMem = 1'b0;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 2048; i++) refMem[i] = 256'd0;
    loadRef();
  endtask

  vec_t vecs[5];
  int   acc, acc2, mark, d0, dn0, nRd, nWr, rdCyc, wrCyc, n;
  logic [10:0]  wrAddr;
  logic [255:0] wrData;

  initial begin
    vecs[0] = '{16'h0023, 16'hBEEF, 1, 1, 0, 11'h002, mkLine(3, 16'hBEEF)};
    vecs[1] = '{16'h8003, 16'h1111, 0, 0, 1, 11'h7FF, 256'd0};
    vecs[2] = '{16'h7FFF, 16'hA5A5, 1, 1, 0, 11'h7FF, mkLine(15, 16'hA5A5)};
    vecs[3] = '{16'h1230, 16'h1234, 1, 1, 0, 11'h123, mkLine(0, 16'h1234)};
    vecs[4] = '{16'h8000, 16'h2222, 0, 0, 1, 11'h7FF, 256'd0};

    clock = 1'b0; reset = 1'b0; in_valid = 1'b0; in_row = 16'd0; in_data = 16'd0;
    loadMem = 1'b0; monOn = 1'b0;
    for (int i = 0; i < 2048; i++) refMem[i] = 256'd0;
    repeat (3) @(negedge clock);
    checkInt("rst_addr", int'(mem_addr), 32'h7FF);
    checkInt("rst_rdEn", int'(mem_rdEn), 0);
    checkInt("rst_wrEn", int'(mem_wrEn), 0);
    checkLine("rst_wrData", mem_wrData, 256'd0);
    checkInt("rst_done", int'(done), 0);
    checkInt("rst_drop", int'(drop), 0);
    checkInt("rst_ready", int'(in_ready), 0);
    loadRef();
    reset = 1'b1;
    monOn = 1'b1;
    @(negedge clock);
    checkInt("ready_after_rst", int'(in_ready), 1);

    // Single-entry vector table
    for (int v = 0; v < 5; v++) begin
      mark = evLog.size(); d0 = dropCount;
      sendEntry(vecs[v].row, vecs[v].data, acc);
      repeat (FLUSH_CYC + 12) @(negedge clock);
      nRd = 0; nWr = 0; rdCyc = -1; wrCyc = -1; wrAddr = 11'h7FF; wrData = 256'd0;
      for (int e = mark; e < evLog.size(); e++) begin
        if (evLog[e].wr) begin
          nWr++; wrCyc = evLog[e].cyc; wrAddr = evLog[e].addr; wrData = evLog[e].data;
        end else begin
          nRd++; rdCyc = evLog[e].cyc;
          checkInt("vec_rd_addr", int'(evLog[e].addr), int'(vecs[v].expAddr));
        end
      end
      checkInt("vec_reads", nRd, vecs[v].expRd);
      checkInt("vec_writes", nWr, vecs[v].expWr);
      checkInt("vec_drops", dropCount - d0, vecs[v].expDrop);
      if (vecs[v].expWr == 1) begin
        checkInt("vec_rd_cycle", rdCyc, acc + 1);
        checkInt("vec_wr_cycle", wrCyc, acc + 4 + FLUSH_CYC);
        checkInt("vec_wr_addr", int'(wrAddr), int'(vecs[v].expAddr));
        checkLine("vec_wr_data", wrData, vecs[v].expLine);
      end
    end

    // Three entries on one line coalesce into a single read and write
    clearMem();
    mark = evLog.size();
    sendEntry(16'h0010, 16'hAAA1, acc);
    sendEntry(16'h0011, 16'hAAA2, acc);
    sendEntry(16'h001F, 16'hAAAF, acc);
    repeat (FLUSH_CYC + 12) @(negedge clock);
    n = evLog.size() - mark;
    checkInt("same_line_events", n, 2);
    if (n == 2) begin
      checkInt("same_line_rd", int'(evLog[mark].wr), 0);
      checkInt("same_line_addr", int'(evLog[mark+1].addr), 1);
      checkLine("same_line_data", evLog[mark+1].data,
                mkLine(0, 16'hAAA1) | mkLine(1, 16'hAAA2) | mkLine(15, 16'hAAAF));
    end

    // Line change: write of the old line, then read of the new one on the next cycle
    clearMem();
    mark = evLog.size();
    sendEntry(16'h0005, 16'h1111, acc);
    sendEntry(16'h0015, 16'h2222, acc2);
    repeat (FLUSH_CYC + 12) @(negedge clock);
    n = evLog.size() - mark;
    checkInt("change_events", n, 4);
    if (n == 4) begin
      checkInt("change_wr0", int'(evLog[mark+1].wr), 1);
      checkInt("change_wr0_addr", int'(evLog[mark+1].addr), 0);
      checkLine("change_wr0_data", evLog[mark+1].data, mkLine(5, 16'h1111));
      checkInt("change_wr0_cycle", evLog[mark+1].cyc, acc2 + 1);
      checkInt("change_rd1", int'(evLog[mark+2].wr), 0);
      checkInt("change_rd1_addr", int'(evLog[mark+2].addr), 1);
      checkInt("change_rd1_cycle", evLog[mark+2].cyc, evLog[mark+1].cyc + 1);
      checkLine("change_wr1_data", evLog[mark+3].data, mkLine(5, 16'h2222));
    end

    // Sentinel flushes the open line, then pulses done
    clearMem();
    mark = evLog.size(); dn0 = doneCount;
    sendEntry(16'h0007, 16'h0A0A, acc);
    sendEntry(16'hFFFF, 16'h0000, acc2);
    repeat (8) @(negedge clock);
    n = evLog.size() - mark;
    checkInt("sent_events", n, 2);
    checkInt("sent_done_count", doneCount - dn0, 1);
    if (n == 2) begin
      checkInt("sent_wr_addr", int'(evLog[mark+1].addr), 0);
      checkLine("sent_wr_data", evLog[mark+1].data, mkLine(7, 16'h0A0A));
      checkInt("sent_done_cycle", lastDoneCyc, evLog[mark+1].cyc + 1);
    end
    checkInt("sent_idle_ready", int'(in_ready), 1);

    // Reset during WAIT discards the line without writing
    clearMem();
    mark = evLog.size();
    sendEntry(16'h0040, 16'h7777, acc);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkInt("rstmid_ready", int'(in_ready), 1);
    checkInt("rstmid_addr", int'(mem_addr), 32'h7FF);
    repeat (FLUSH_CYC + 12) @(negedge clock);
    nWr = 0;
    for (int e = mark; e < evLog.size(); e++) if (evLog[e].wr) nWr++;
    checkInt("rstmid_writes", nWr, 0);

    // Randomized stream against a line-level memory model
    for (int i = 0; i < 2048; i++) refMem[i] = 256'd0;
    for (int i = 0; i < 8; i++)
      refMem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    loadRef();
    d0 = dropCount; dn0 = doneCount; n = 0;
    for (int k = 0; k < 60; k++) begin
      logic [15:0] row, dat;
      dat = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        row = 16'h8000 | 16'($urandom_range(0, 32767));
        if (row == 16'hFFFF) row = 16'h8000;
        n++;
      end else begin
        row = 16'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
        refMem[row[14:4]][row[3:0]*16 +: 16] = dat;
      end
      sendEntry(row, dat, acc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(10, 25)) @(negedge clock);
      else repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    sendEntry(16'hFFFF, 16'h0000, acc);
    for (int t = 0; t < 300 && doneCount == dn0; t++) @(negedge clock);
    repeat (4) @(negedge clock);
    checkInt("rand_done", doneCount - dn0, 1);
    checkInt("rand_drops", dropCount - d0, n);
    for (int i = 0; i < 8; i++) checkLine("rand_line", memArr[i], refMem[i]);

    checkInt("strobe_overlap", overlapCnt, 0);
    checkInt("idle_addr", badAddrCnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
